// File: rtl/lcd_i2c_pkg.sv
// Shared types and constants for the PCF8574-style I2C target.
package lcd_i2c_pkg;

  // Protocol FSM states
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StIgnore
  } i2c_state_e;

  // PCF8574 pin roles on the LCD backpack
  localparam int unsigned P_RS    = 0;
  localparam int unsigned P_RW    = 1;
  localparam int unsigned P_EN    = 2;
  localparam int unsigned P_BL    = 3;
  localparam int unsigned P_D_LSB = 4;

  localparam logic [6:0] DEF_ADDR = 7'h27;

endpackage

// File: rtl/i2c_pcf8574_target_if.sv
// Port-side signal bundle of the PCF8574 target: input pins, output pins, status and LCD decode.
interface i2c_pcf8574_target_if;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic       wr_stb;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_stb;

  modport slave (
    input  port_in,
    output port_out, wr_stb, busy, lcd_data, lcd_rs, lcd_stb
  );

  modport master (
    output port_in,
    input  port_out, wr_stb, busy, lcd_data, lcd_rs, lcd_stb
  );
endinterface

// File: rtl/i2c_line_sync.sv
// Input synchroniser for one I2C line, with rising/falling edge detect on the synchronised value.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the line through the sync chain; reset to the idle (high) bus level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_pcf8574_target.sv
// I2C target emulating a PCF8574 8-bit expander: address match, ACK, byte writes to port_out,
// reads from a port_in snapshot. Optional HD44780 nibble decoder enabled by LCD_DECODE_EN.
module i2c_pcf8574_target
  import lcd_i2c_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR    = DEF_ADDR,
  parameter logic [7:0]  PORT_RESET  = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  i2c_pcf8574_target_if.slave   pins
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic bus_start, bus_stop;
  assign bus_start = sda_fall & scl_lvl;
  assign bus_stop  = sda_rise & scl_lvl;

  i2c_state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] rx_q;
  logic [7:0] tx_q;
  logic       rw_q;
  logic       oe_q;
  logic [7:0] port_out_q;
  logic       wr_stb_q;
  logic       busy_q;

  // Open drain: only ever pull low or release
  assign sda = oe_q ? 1'b0 : 1'bz;

  // Protocol FSM; sda updates only on the cycle of a detected scl fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      port_out_q <= PORT_RESET;
      wr_stb_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      if (bus_start) begin
        // Repeated START drops any partial byte
        state_q <= StAddr;
        cnt_q   <= 4'd0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (bus_stop) begin
        state_q <= StIdle;
        cnt_q   <= 4'd0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StAddr: begin
            if (scl_rise && cnt_q < 4'd8) begin
              rx_q  <= {rx_q[6:0], sda_lvl};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q <= 4'd0;
              // General call (address 0) is never acknowledged
              if (rx_q[7:1] == I2C_ADDR && rx_q[7:1] != 7'h00) begin
                oe_q    <= 1'b1;
                rw_q    <= rx_q[0];
                busy_q  <= 1'b1;
                state_q <= StAddrAck;
              end else begin
                state_q <= StIgnore;
              end
            end
          end
          StAddrAck: begin
            if (scl_rise && rw_q) begin
              tx_q <= pins.port_in;
            end else if (scl_fall) begin
              cnt_q <= 4'd0;
              if (rw_q) begin
                oe_q    <= ~tx_q[7];
                state_q <= StRdData;
              end else begin
                oe_q    <= 1'b0;
                state_q <= StWrData;
              end
            end
          end
          StWrData: begin
            if (scl_rise && cnt_q < 4'd8) begin
              rx_q  <= {rx_q[6:0], sda_lvl};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              oe_q    <= 1'b1;
              state_q <= StWrAck;
            end
          end
          StWrAck: begin
            // Byte is committed only once its ACK clock completes
            if (scl_fall) begin
              oe_q       <= 1'b0;
              port_out_q <= rx_q;
              wr_stb_q   <= 1'b1;
              cnt_q      <= 4'd0;
              state_q    <= StWrData;
            end
          end
          StRdData: begin
            if (scl_rise && cnt_q < 4'd8) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                oe_q    <= 1'b0;
                state_q <= StRdAck;
              end else begin
                tx_q <= {tx_q[6:0], 1'b0};
                oe_q <= ~tx_q[6];
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              if (!sda_lvl) begin
                tx_q <= pins.port_in;
              end else begin
                busy_q  <= 1'b0;
                state_q <= StIgnore;
              end
            end else if (scl_fall) begin
              cnt_q   <= 4'd0;
              oe_q    <= ~tx_q[7];
              state_q <= StRdData;
            end
          end
          StIdle, StIgnore: begin
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign pins.port_out = port_out_q;
  assign pins.wr_stb   = wr_stb_q;
  assign pins.busy     = busy_q;

`ifdef LCD_DECODE_EN
  logic       en_prev_q;
  logic       phase_low_q;
  logic [3:0] hi_q;
  logic [7:0] lcd_data_q;
  logic       lcd_rs_q;
  logic       lcd_stb_q;

  // Reassemble HD44780 bytes from two EN falling-edge nibble writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_prev_q   <= PORT_RESET[P_EN];
      phase_low_q <= 1'b0;
      hi_q        <= 4'h0;
      lcd_data_q  <= 8'h00;
      lcd_rs_q    <= 1'b0;
      lcd_stb_q   <= 1'b0;
    end else begin
      lcd_stb_q <= 1'b0;
      if (wr_stb_q) begin
        en_prev_q <= port_out_q[P_EN];
        if (en_prev_q && !port_out_q[P_EN] && !port_out_q[P_RW]) begin
          if (!phase_low_q) begin
            hi_q        <= port_out_q[P_D_LSB +: 4];
            phase_low_q <= 1'b1;
          end else begin
            lcd_data_q  <= {hi_q, port_out_q[P_D_LSB +: 4]};
            lcd_rs_q    <= port_out_q[P_RS];
            lcd_stb_q   <= 1'b1;
            phase_low_q <= 1'b0;
          end
        end
      end
    end
  end

  assign pins.lcd_data = lcd_data_q;
  assign pins.lcd_rs   = lcd_rs_q;
  assign pins.lcd_stb  = lcd_stb_q;
`else
  assign pins.lcd_data = 8'h00;
  assign pins.lcd_rs   = 1'b0;
  assign pins.lcd_stb  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_pcf8574_target.sv
// Directed bench for i2c_pcf8574_target: bit-banged I2C initiator with open-drain sda.
module tb_i2c_pcf8574_target;

  localparam time Q = 80ns;  // quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int lcd_cnt = 0;
  int dut_low_cnt = 0;

  i2c_pcf8574_target_if bus ();

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_pcf8574_target dut (
    .clk  (clk),
    .rst  (rst),
    .scl  (scl),
    .sda  (sda),
    .pins (bus)
  );

  always #5ns clk = ~clk;

  always @(posedge clk) begin
    if (bus.wr_stb === 1'b1) wr_cnt++;
    if (bus.lcd_stb === 1'b1) lcd_cnt++;
    if (!m_low && sda === 1'b0) dut_low_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    m_low = 1'b0; scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b0; #Q;
    #Q;
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; #Q;
    scl = 1'b1; #(2 * Q);
    scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    ack = (sda === 1'b0);
    #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] v);
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_low = 1'b0; #Q;
      scl = 1'b1; #Q;
      v = {v[6:0], sda};
      #Q;
      scl = 1'b0; #Q;
    end
    m_low = ack; #Q;
    scl = 1'b1; #(2 * Q);
    scl = 1'b0; #Q;
  endtask

  initial begin
    logic       ack;
    logic [7:0] v;
    int         wr0;
    int         low0;
    int         lcd0;

    bus.port_in = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset port_out", bus.port_out, 8'hFF);
    check("reset busy", {7'd0, bus.busy}, 8'h00);
    check("reset wr_stb", {7'd0, bus.wr_stb}, 8'h00);
    check("reset sda released", {7'd0, sda}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Address mismatch: 0x20 must be ignored entirely
    wr0 = wr_cnt; low0 = dut_low_cnt;
    i2c_start();
    send_byte(8'h40, ack);
    check("t2 addr nack", {7'd0, ack}, 8'h00);
    send_byte(8'h55, ack);
    check("t2 data nack", {7'd0, ack}, 8'h00);
    i2c_stop();
    check("t2 sda never pulled", dut_low_cnt[7:0] - low0[7:0], 8'h00);
    check("t2 port_out", bus.port_out, 8'hFF);
    check("t2 no wr_stb", wr_cnt[7:0] - wr0[7:0], 8'h00);

    // Single-byte write
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'h4E, ack);
    check("t1 addr ack", {7'd0, ack}, 8'h01);
    send_byte(8'hA5, ack);
    check("t1 data ack", {7'd0, ack}, 8'h01);
    check("t1 busy mid", {7'd0, bus.busy}, 8'h01);
    i2c_stop();
    check("t1 port_out", bus.port_out, 8'hA5);
    check("t1 wr_stb count", wr_cnt[7:0] - wr0[7:0], 8'h01);
    check("t1 busy after stop", {7'd0, bus.busy}, 8'h00);

    // Read two bytes, master ACK then NACK
    bus.port_in = 8'h3C;
    i2c_start();
    send_byte(8'h4F, ack);
    check("t3 addr ack", {7'd0, ack}, 8'h01);
    bus.port_in = 8'hC3;
    read_byte(1'b1, v);
    check("t3 byte0", v, 8'h3C);
    read_byte(1'b0, v);
    check("t3 byte1", v, 8'hC3);
    check("t3 busy after nack", {7'd0, bus.busy}, 8'h00);
    check("t3 sda released", {7'd0, sda}, 8'h01);
    i2c_stop();

    // Repeated START discards a partial byte
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'h4E, ack);
    send_byte(8'h12, ack);
    check("t4 byte ack", {7'd0, ack}, 8'h01);
    check("t4 port_out first", bus.port_out, 8'h12);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_rstart();
    check("t4 busy after rstart", {7'd0, bus.busy}, 8'h00);
    check("t4 port_out kept", bus.port_out, 8'h12);
    send_byte(8'h4E, ack);
    check("t4 readdr ack", {7'd0, ack}, 8'h01);
    send_byte(8'h77, ack);
    i2c_stop();
    check("t4 port_out final", bus.port_out, 8'h77);
    check("t4 wr_stb count", wr_cnt[7:0] - wr0[7:0], 8'h02);

    // Reset while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(v_addr_bit(i));
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    check("t5 ack driven", {7'd0, sda}, 8'h00);
    rst = 1'b1;
    #1;
    check("t5 sda released on rst", {7'd0, sda}, 8'h01);
    check("t5 port_out reset", bus.port_out, 8'hFF);
    check("t5 busy reset", {7'd0, bus.busy}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    i2c_start();
    send_byte(8'h4E, ack);
    check("t5 recover addr ack", {7'd0, ack}, 8'h01);
    send_byte(8'h01, ack);
    i2c_stop();
    check("t5 recover port_out", bus.port_out, 8'h01);

`ifdef LCD_DECODE_EN
    // Fresh nibble phase, then two EN-strobed nibbles 0x4 and 0x1 with RS=1
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    lcd0 = lcd_cnt; wr0 = wr_cnt;
    i2c_start();
    send_byte(8'h4E, ack);
    send_byte(8'h4D, ack);
    send_byte(8'h49, ack);
    send_byte(8'h1D, ack);
    send_byte(8'h19, ack);
    i2c_stop();
    check("t6 wr_stb count", wr_cnt[7:0] - wr0[7:0], 8'h04);
    check("t6 lcd_stb count", lcd_cnt[7:0] - lcd0[7:0], 8'h01);
    check("t6 lcd_data", bus.lcd_data, 8'h41);
    check("t6 lcd_rs", {7'd0, bus.lcd_rs}, 8'h01);
`else
    lcd0 = 0;
    check("lcd_data tied", bus.lcd_data, 8'h00);
    check("lcd_rs tied", {7'd0, bus.lcd_rs}, 8'h00);
    check("lcd_stb never", lcd_cnt[7:0] - lcd0[7:0], 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Address byte 0x4E (0x27, write) bit lookup for the manual ACK-slot sequence
  function automatic logic v_addr_bit(input int i);
    logic [7:0] a;
    a = 8'h4E;
    return a[i];
  endfunction

endmodule
